// File: rtl/cpu_data_path_if.sv
// Control/memory-facing signal bundle of the 8-bit CPU data path.
// The master side (control unit plus memory) drives strobes and read data; the data path answers.
interface cpu_data_path_if;
    logic [7:0] from_memory;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel;
    logic [1:0] Bus2_Sel;
    logic       IR_Load;
    logic       MAR_Load;
    logic       PC_Load;
    logic       PC_Inc;
    logic       A_Load;
    logic       B_Load;
    logic       CCR_Load;
    logic [7:0] address;
    logic [7:0] to_memory;
    logic [7:0] IR_out;
    logic [3:0] CCR_Result;

    modport master (
        output from_memory, ALU_Sel, Bus1_Sel, Bus2_Sel,
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
        input  address, to_memory, IR_out, CCR_Result
    );

    modport slave (
        input  from_memory, ALU_Sel, Bus1_Sel, Bus2_Sel,
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
        output address, to_memory, IR_out, CCR_Result
    );
endinterface

// File: rtl/cpu_data_path.sv
// 8-bit CPU data path: IR/MAR/PC/A/B/CCR registers, two internal buses and an NZVC ALU.
// Purely strobe driven; the control unit owns every select and load.
module cpu_data_path (
    input  logic              Clk,
    input  logic              Reset,
    cpu_data_path_if.slave    bus
);
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_INC = 3'b001,
        ALU_SUB = 3'b010,
        ALU_DEC = 3'b011,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101,
        ALU_XOR = 3'b110,
        ALU_NOT = 3'b111
    } alu_op_e;

    logic [7:0] ir_q, ir_d, mar_q, mar_d, pc_q, pc_d, a_q, a_d, b_q, b_d;
    logic [3:0] ccr_q, ccr_d;
    logic [7:0] bus1, bus2, alu_result;
    logic [8:0] alu_wide;
    logic       alu_v;
    logic [3:0] nzvc;

    always_comb begin
        case (bus.Bus1_Sel)
            2'b00:   bus1 = pc_q;
            2'b01:   bus1 = a_q;
            2'b10:   bus1 = b_q;
            default: bus1 = 8'h00;
        endcase
    end

    always_comb begin
        case (bus.Bus2_Sel)
            2'b00:   bus2 = alu_result;
            2'b01:   bus2 = bus1;
            2'b10:   bus2 = bus.from_memory;
            default: bus2 = 8'h00;
        endcase
    end

    // Bit 8 of the widened result is carry-out for additions and borrow for subtractions.
    always_comb begin
        alu_wide = 9'h000;
        alu_v    = 1'b0;
        case (alu_op_e'(bus.ALU_Sel))
            ALU_ADD: begin
                alu_wide = {1'b0, bus1} + {1'b0, b_q};
                alu_v    = (bus1[7] == b_q[7]) && (alu_wide[7] != bus1[7]);
            end
            ALU_INC: begin
                alu_wide = {1'b0, bus1} + 9'd1;
                alu_v    = (bus1 == 8'h7F);
            end
            ALU_SUB: begin
                alu_wide = {1'b0, bus1} - {1'b0, b_q};
                alu_v    = (bus1[7] != b_q[7]) && (alu_wide[7] != bus1[7]);
            end
            ALU_DEC: begin
                alu_wide = {1'b0, bus1} - 9'd1;
                alu_v    = (bus1 == 8'h80);
            end
            ALU_AND: alu_wide = {1'b0, bus1 & b_q};
            ALU_OR:  alu_wide = {1'b0, bus1 | b_q};
            ALU_XOR: alu_wide = {1'b0, bus1 ^ b_q};
            default: alu_wide = {1'b0, ~bus1};
        endcase
    end

    assign alu_result = alu_wide[7:0];
    assign nzvc       = {alu_result[7], (alu_result == 8'h00), alu_v, alu_wide[8]};

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        ir_d  = ir_q;
        mar_d = mar_q;
        pc_d  = pc_q;
        a_d   = a_q;
        b_d   = b_q;
        ccr_d = ccr_q;
        if (bus.IR_Load)  ir_d  = bus2;
        if (bus.MAR_Load) mar_d = bus2;
        if (bus.A_Load)   a_d   = bus2;
        if (bus.B_Load)   b_d   = bus2;
        if (bus.CCR_Load) ccr_d = nzvc;
        if (bus.PC_Load)      pc_d = bus2;
        else if (bus.PC_Inc)  pc_d = pc_q + 8'd1;
    end

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ir_q  <= 8'h00;
            mar_q <= 8'h00;
            pc_q  <= 8'h00;
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            ccr_q <= 4'h0;
        end else begin
            ir_q  <= ir_d;
            mar_q <= mar_d;
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ccr_q <= ccr_d;
        end
    end

    assign bus.address    = mar_q;
    assign bus.to_memory  = bus1;
    assign bus.IR_out     = ir_q;
    assign bus.CCR_Result = ccr_q;
endmodule

// File: tb/tb_cpu_data_path.sv
// Directed bench for cpu_data_path; expectations are queued with the stimulus and
// checked against the outputs shortly after the following rising edge.
module tb_cpu_data_path;
    logic Clk = 1'b0;
    logic Reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    typedef enum logic [1:0] {OBS_ADDR, OBS_TOMEM, OBS_IR, OBS_CCR} obs_e;
    typedef struct {
        string      tag;
        obs_e       sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];

    cpu_data_path_if bus ();

    cpu_data_path dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] observe(input obs_e s);
        case (s)
            OBS_ADDR:  return bus.address;
            OBS_TOMEM: return bus.to_memory;
            OBS_IR:    return bus.IR_out;
            default:   return {4'h0, bus.CCR_Result};
        endcase
    endfunction

    task automatic push(input string tag, input obs_e sel, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t       e;
        logic [7:0] got;
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            got = observe(e.sel);
            tests_run++;
            assert (got === e.exp) else begin
                tests_failed++;
                $error("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
            end
        end
    endtask

    task automatic idle();
        bus.from_memory = 8'h00;
        bus.ALU_Sel     = 3'b000;
        bus.Bus1_Sel    = 2'b00;
        bus.Bus2_Sel    = 2'b11;
        bus.IR_Load     = 1'b0;
        bus.MAR_Load    = 1'b0;
        bus.PC_Load     = 1'b0;
        bus.PC_Inc      = 1'b0;
        bus.A_Load      = 1'b0;
        bus.B_Load      = 1'b0;
        bus.CCR_Load    = 1'b0;
    endtask

    task automatic all_loads(input logic v);
        bus.IR_Load  = v;
        bus.MAR_Load = v;
        bus.PC_Load  = v;
        bus.PC_Inc   = v;
        bus.A_Load   = v;
        bus.B_Load   = v;
        bus.CCR_Load = v;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Releases the strobes, selects what Bus1 shows on to_memory, then checks the queue.
    task automatic observe_with(input logic [1:0] b1);
        idle();
        bus.Bus1_Sel = b1;
        #1;
        check_sb();
    endtask

    task automatic load_a(input logic [7:0] v);
        bus.from_memory = v;
        bus.Bus2_Sel    = 2'b10;
        bus.A_Load      = 1'b1;
        tick();
        idle();
    endtask

    task automatic alu_step(input string tag, input logic [2:0] op, input logic ccr_ld,
                            input logic [7:0] a_exp, input logic [3:0] ccr_exp);
        bus.ALU_Sel  = op;
        bus.Bus1_Sel = 2'b01;
        bus.Bus2_Sel = 2'b00;
        bus.A_Load   = 1'b1;
        bus.CCR_Load = ccr_ld;
        push({tag, "_a"}, OBS_TOMEM, a_exp);
        push({tag, "_ccr"}, OBS_CCR, {4'h0, ccr_exp});
        tick();
        observe_with(2'b01);
    endtask

    initial begin
        idle();
        Reset = 1'b0;
        all_loads(1'b1);
        bus.from_memory = 8'hAA;
        bus.Bus2_Sel    = 2'b10;
        push("rst_address", OBS_ADDR, 8'h00);
        push("rst_to_memory", OBS_TOMEM, 8'h00);
        push("rst_ir", OBS_IR, 8'h00);
        push("rst_ccr", OBS_CCR, 8'h00);
        tick();
        Reset = 1'b1;
        observe_with(2'b00);
        push("rst_a", OBS_TOMEM, 8'h00);
        observe_with(2'b01);
        push("rst_b", OBS_TOMEM, 8'h00);
        observe_with(2'b10);

        // Immediate loads of A and B from memory.
        load_a(8'h07);
        bus.from_memory = 8'h09;
        bus.Bus2_Sel    = 2'b10;
        bus.B_Load      = 1'b1;
        tick();
        push("imm_a", OBS_TOMEM, 8'h07);
        observe_with(2'b01);
        push("imm_b", OBS_TOMEM, 8'h09);
        observe_with(2'b10);

        alu_step("sub_neg", 3'b010, 1'b1, 8'hFE, 4'b1001);
        load_a(8'h09);
        alu_step("sub_zero", 3'b010, 1'b1, 8'h00, 4'b0100);

        load_a(8'hFF);
        alu_step("inc_ff", 3'b001, 1'b1, 8'h00, 4'b0101);
        load_a(8'h7F);
        alu_step("inc_7f", 3'b001, 1'b1, 8'h80, 4'b1010);
        load_a(8'h00);
        alu_step("dec_00", 3'b011, 1'b1, 8'hFF, 4'b1001);

        load_a(8'hF8);
        alu_step("add_carry", 3'b000, 1'b1, 8'h01, 4'b0001);

        load_a(8'h0C);
        alu_step("and", 3'b100, 1'b1, 8'h08, 4'b0000);
        alu_step("or", 3'b101, 1'b1, 8'h09, 4'b0000);
        alu_step("xor", 3'b110, 1'b1, 8'h00, 4'b0100);
        alu_step("not", 3'b111, 1'b1, 8'hFF, 4'b1000);

        load_a(8'h09);
        alu_step("ccr_hold", 3'b010, 1'b0, 8'h00, 4'b1000);

        // Program counter increment, load priority and wrap.
        for (int i = 0; i < 3; i++) begin
            bus.PC_Inc = 1'b1;
            tick();
            idle();
        end
        push("pc_inc3", OBS_TOMEM, 8'h03);
        observe_with(2'b00);
        bus.from_memory = 8'h14;
        bus.Bus2_Sel    = 2'b10;
        bus.PC_Load     = 1'b1;
        bus.PC_Inc      = 1'b1;
        push("pc_load_prio", OBS_TOMEM, 8'h14);
        tick();
        observe_with(2'b00);
        bus.from_memory = 8'hFF;
        bus.Bus2_Sel    = 2'b10;
        bus.PC_Load     = 1'b1;
        tick();
        idle();
        bus.PC_Inc = 1'b1;
        push("pc_wrap", OBS_TOMEM, 8'h00);
        tick();
        observe_with(2'b00);
        bus.from_memory = 8'h80;
        bus.Bus2_Sel    = 2'b10;
        bus.MAR_Load    = 1'b1;
        push("mar_load", OBS_ADDR, 8'h80);
        tick();
        observe_with(2'b00);

        bus.from_memory = 8'h3C;
        bus.Bus2_Sel    = 2'b10;
        bus.IR_Load     = 1'b1;
        bus.MAR_Load    = 1'b1;
        bus.B_Load      = 1'b1;
        push("multi_ir", OBS_IR, 8'h3C);
        push("multi_mar", OBS_ADDR, 8'h3C);
        push("multi_b", OBS_TOMEM, 8'h3C);
        tick();
        observe_with(2'b10);

        // Bus2 taking Bus1, and the constant-zero select codes.
        bus.from_memory = 8'h5A;
        bus.Bus2_Sel    = 2'b10;
        bus.PC_Load     = 1'b1;
        tick();
        idle();
        bus.Bus1_Sel = 2'b00;
        bus.Bus2_Sel = 2'b01;
        bus.IR_Load  = 1'b1;
        push("bus2_from_bus1", OBS_IR, 8'h5A);
        tick();
        observe_with(2'b00);
        push("bus1_zero", OBS_TOMEM, 8'h00);
        observe_with(2'b11);
        load_a(8'h55);
        bus.Bus2_Sel = 2'b11;
        bus.A_Load   = 1'b1;
        push("bus2_zero", OBS_TOMEM, 8'h00);
        tick();
        observe_with(2'b01);

        load_a(8'h66);
        Reset = 1'b0;
        all_loads(1'b1);
        bus.from_memory = 8'h77;
        bus.Bus2_Sel    = 2'b10;
        push("mid_rst_address", OBS_ADDR, 8'h00);
        push("mid_rst_ir", OBS_IR, 8'h00);
        push("mid_rst_ccr", OBS_CCR, 8'h00);
        tick();
        Reset = 1'b1;
        push("mid_rst_pc", OBS_TOMEM, 8'h00);
        observe_with(2'b00);
        push("mid_rst_a", OBS_TOMEM, 8'h00);
        observe_with(2'b01);
        push("mid_rst_b", OBS_TOMEM, 8'h00);
        observe_with(2'b10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
